checkpoint_seq_monitor: RTL and testbench



---
 rtl/checkpoint_seq_monitor.sv | 213 +++++++++++++++++++++
 tb/tb_checkpoint_seq_monitor.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checkpoint_seq_monitor.sv
// Purpose: checks the firmware checkpoint bus for START_TAG, an ordered table of expected values, then END_TAG.
// Latency: chk_i settled before edge N gives match_pulse after edge N+STABLE; pass/fail follow the deciding match.
// Backpressure: none; the monitor only observes the bus and never stalls it.
module checkpoint_seq_monitor #(
    parameter int          DW        = 16,
    parameter int          DEPTH     = 8,
    parameter int          TMO_W     = 24,
    parameter int          STABLE    = 2,
    parameter logic [DW-1:0] START_TAG = 16'hAB40,
    parameter logic [DW-1:0] END_TAG   = 16'hAB51,
    parameter bit          STRICT    = 1'b1
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [DW-1:0]            chk_i,
    input  logic                     exp_we,
    input  logic [$clog2(DEPTH)-1:0] exp_addr,
    input  logic [DW-1:0]            exp_wdata,
    input  logic [$clog2(DEPTH):0]   num_exp,
    input  logic [TMO_W-1:0]         tmo_limit,
    input  logic                     start,
    input  logic                     clear,
    output logic                     busy,
    output logic                     pass,
    output logic                     fail,
    output logic [1:0]               fail_code,
    output logic                     match_pulse,
    output logic [$clog2(DEPTH):0]   match_idx
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SCW = $clog2(STABLE + 1);

    localparam logic [SCW-1:0] STAB_LAST = SCW'(STABLE - 1);
    localparam logic [SCW-1:0] STAB_MAX  = SCW'(STABLE);
    localparam logic [AW:0]    NUM_MAX   = (AW + 1)'(DEPTH);

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_TIMEOUT = 2'd1;
    localparam logic [1:0] CODE_EARLY   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_WAIT_END,
        S_PASS,
        S_FAIL
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       w_code_nxt;

    logic [DW-1:0]    r_tab [DEPTH];
    logic [DW-1:0]    r_samp;
    logic [SCW-1:0]   r_stab;
    logic [SCW-1:0]   r_end_stab;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] r_lim;
    logic [AW:0]      r_num;
    logic [AW:0]      r_idx;
    logic             r_pulse;
    logic [1:0]       r_fail_code;

    logic             w_busy;
    logic [DW-1:0]    w_target;
    logic             w_hit;
    logic             w_match;
    logic             w_early_end;
    logic             w_tmo_exp;
    logic [AW:0]      w_idx_inc;
    logic [AW:0]      w_num_clamp;

    // Value the sampled bus is currently compared against, plus match/timeout/early-end conditions.
    always_comb begin
        w_busy = (r_state == S_ARMED) || (r_state == S_RUN) || (r_state == S_WAIT_END);
        case (r_state)
            S_ARMED: w_target = START_TAG;
            S_RUN:   w_target = r_tab[r_idx[AW-1:0]];
            default: w_target = END_TAG;
        endcase
        w_hit       = w_busy && (r_samp == w_target);
        w_match     = w_hit && (r_stab == STAB_LAST);
        w_early_end = STRICT && (r_state == S_RUN) && (r_samp == END_TAG) && (r_end_stab == STAB_LAST);
        w_tmo_exp   = (r_lim != '0) && (r_tmo == r_lim - TMO_W'(1));
        w_idx_inc   = r_idx + 1'b1;
        w_num_clamp = (num_exp > NUM_MAX) ? NUM_MAX : num_exp;
    end

    // Next state and failure code; clear beats everything, a match beats early-end and timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_fail_code;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_code_nxt  = CODE_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (w_match) begin
                        w_state_nxt = (r_num == '0) ? S_WAIT_END : S_RUN;
                    end else if (w_tmo_exp) begin
                        w_state_nxt = S_FAIL;
                        w_code_nxt  = CODE_TIMEOUT;
                    end
                end
                S_RUN: begin
                    if (w_match) begin
                        if (w_idx_inc == r_num) begin
                            w_state_nxt = S_WAIT_END;
                        end
                    end else if (w_early_end) begin
                        w_state_nxt = S_FAIL;
                        w_code_nxt  = CODE_EARLY;
                    end else if (w_tmo_exp) begin
                        w_state_nxt = S_FAIL;
                        w_code_nxt  = CODE_TIMEOUT;
                    end
                end
                S_WAIT_END: begin
                    if (w_match) begin
                        w_state_nxt = S_PASS;
                    end else if (w_tmo_exp) begin
                        w_state_nxt = S_FAIL;
                        w_code_nxt  = CODE_TIMEOUT;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Expected-value table; only writable while idle so a running check sees a frozen table.
    always_ff @(posedge wb_clk_i) begin
        if ((r_state == S_IDLE) && exp_we) begin
            r_tab[exp_addr] <= exp_wdata;
        end
    end

    // Bus sampling, stability/timeout counters, progress index and latched run configuration.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_samp      <= '0;
            r_stab      <= '0;
            r_end_stab  <= '0;
            r_tmo       <= '0;
            r_lim       <= '0;
            r_num       <= '0;
            r_idx       <= '0;
            r_pulse     <= 1'b0;
            r_fail_code <= CODE_NONE;
        end else begin
            r_samp      <= chk_i;
            r_pulse     <= w_match && !clear;
            r_fail_code <= w_code_nxt;

            if ((r_state == S_IDLE) && start && !clear) begin
                r_num <= w_num_clamp;
                r_lim <= tmo_limit;
            end

            // Every accepted match restarts stability and timeout measurement.
            if (clear || !w_busy || w_match) begin
                r_stab <= '0;
                r_tmo  <= '0;
            end else begin
                r_tmo  <= r_tmo + 1'b1;
                if (w_hit) begin
                    r_stab <= (r_stab == STAB_MAX) ? r_stab : r_stab + 1'b1;
                end else begin
                    r_stab <= '0;
                end
            end

            if (clear || (r_state != S_RUN) || w_match || (r_samp != END_TAG)) begin
                r_end_stab <= '0;
            end else if (r_end_stab != STAB_MAX) begin
                r_end_stab <= r_end_stab + 1'b1;
            end

            if (clear || (r_state == S_IDLE)) begin
                r_idx <= '0;
            end else if ((r_state == S_RUN) && w_match) begin
                r_idx <= w_idx_inc;
            end
        end
    end

    assign busy        = w_busy;
    assign pass        = (r_state == S_PASS);
    assign fail        = (r_state == S_FAIL);
    assign fail_code   = r_fail_code;
    assign match_pulse = r_pulse;
    assign match_idx   = r_idx;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Purpose: directed plus randomized bench for checkpoint_seq_monitor against a timestamp-based reference model.
// Latency: outputs are compared 1 time unit after every rising edge.
// Backpressure: not applicable; stimulus is driven freely between edges.
module tb_checkpoint_seq_monitor;

    localparam int          STABLE = 2;
    localparam logic [15:0] ST     = 16'hAB40;
    localparam logic [15:0] EN     = 16'hAB51;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] chk_i = '0;
    logic        exp_we = 1'b0;
    logic [2:0]  exp_addr = '0;
    logic [15:0] exp_wdata = '0;
    logic [3:0]  num_exp = '0;
    logic [23:0] tmo_limit = '0;
    logic        start = 1'b0;
    logic        clear = 1'b0;

    logic        busy, pass, fail, match_pulse;
    logic [1:0]  fail_code;
    logic [3:0]  match_idx;
    logic        busy_ns, pass_ns, fail_ns, match_pulse_ns;
    logic [1:0]  fail_code_ns;
    logic [3:0]  match_idx_ns;

    checkpoint_seq_monitor dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .chk_i(chk_i), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_wdata(exp_wdata), .num_exp(num_exp), .tmo_limit(tmo_limit), .start(start), .clear(clear),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code), .match_pulse(match_pulse),
        .match_idx(match_idx)
    );

    checkpoint_seq_monitor #(.STRICT(1'b0)) dut_ns (
        .wb_clk_i(clk), .wb_rst_i(rst), .chk_i(chk_i), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_wdata(exp_wdata), .num_exp(num_exp), .tmo_limit(tmo_limit), .start(start), .clear(clear),
        .busy(busy_ns), .pass(pass_ns), .fail(fail_ns), .fail_code(fail_code_ns), .match_pulse(match_pulse_ns),
        .match_idx(match_idx_ns)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    int     pulses = 0;
    longint last_pulse_cyc = 0;

    // Reference model: phase 0 idle, 1 armed, 2 run, 3 wait-end, 4 pass, 5 fail.
    // Stability is judged from timestamps: when the current sample value arrived and when the last event happened.
    int          m_ph = 0;
    int          m_code = 0;
    int          m_idx = 0;
    int          m_n = 0;
    longint      m_lim = 0;
    bit          m_pulse = 1'b0;
    logic [15:0] m_s = '0;
    longint      m_vstart = 0;
    longint      m_last = 0;
    logic [15:0] m_tab [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic [15:0] tgt;
        logic [15:0] nv;
        longint      since;
        bit          hit_ok, early, tmo;
        if (m_ph == 0 && exp_we) m_tab[exp_addr] = exp_wdata;
        m_pulse = 1'b0;
        if (rst) begin
            m_ph = 0; m_code = 0; m_idx = 0; m_n = 0; m_lim = 0;
        end else if (clear) begin
            m_ph = 0; m_code = 0; m_idx = 0;
        end else if (m_ph == 0) begin
            if (start) begin
                m_ph = 1; m_idx = 0; m_last = cyc;
                m_n = (num_exp > 8) ? 8 : int'(num_exp);
                m_lim = longint'(tmo_limit);
            end
        end else if (m_ph >= 1 && m_ph <= 3) begin
            tgt    = (m_ph == 1) ? ST : (m_ph == 2) ? m_tab[m_idx] : EN;
            since  = (m_vstart > m_last) ? m_vstart : m_last;
            hit_ok = (m_s == tgt) && (cyc - since == STABLE);
            early  = (m_ph == 2) && (m_s == EN) && (cyc - since == STABLE);
            tmo    = (m_lim != 0) && (cyc - m_last == m_lim);
            if (hit_ok) begin
                m_pulse = 1'b1;
                m_last  = cyc;
                if (m_ph == 1) m_ph = (m_n == 0) ? 3 : 2;
                else if (m_ph == 2) begin
                    m_idx++;
                    if (m_idx == m_n) m_ph = 3;
                end else m_ph = 4;
            end else if (early) begin
                m_ph = 5; m_code = 2;
            end else if (tmo) begin
                m_ph = 5; m_code = 1;
            end
        end
        nv = rst ? 16'h0000 : chk_i;
        if (nv !== m_s) begin
            m_s = nv;
            m_vstart = cyc;
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("busy", busy, (m_ph >= 1 && m_ph <= 3) ? 1 : 0);
        check("pass", pass, (m_ph == 4) ? 1 : 0);
        check("fail", fail, (m_ph == 5) ? 1 : 0);
        check("fail_code", fail_code, m_code);
        check("match_pulse", match_pulse, m_pulse);
        check("match_idx", match_idx, m_idx);
        if (match_pulse === 1'b1) begin
            pulses++;
            last_pulse_cyc = cyc;
        end
    endtask

    task automatic hold(input logic [15:0] v, input int n);
        chk_i = v;
        repeat (n) step();
    endtask

    task automatic load4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
        logic [15:0] vals [4];
        vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
        for (int i = 0; i < 4; i++) begin
            exp_we = 1'b1; exp_addr = 3'(i); exp_wdata = vals[i];
            step();
        end
        exp_we = 1'b0;
    endtask

    task automatic go(input logic [3:0] n, input logic [23:0] lim);
        num_exp = n; tmo_limit = lim; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic full_seq();
        hold(ST, 5); hold(16'd40, 5); hold(16'd893, 5); hold(16'd6023, 5); hold(16'd9073, 5); hold(EN, 5);
    endtask

    task automatic wait_fail(input bit ns, input int budget, output longint at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((ns ? fail_ns : fail) === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                return;
            end
        end
    endtask

    initial begin
        longint at;
        bit     ok;
        int     r;
        int     n;
        logic [15:0] v;

        // Reset state
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_match_idx", match_idx, 0);
        check("rst_fail_code", fail_code, 0);
        rst = 1'b0;
        step();

        // Nominal pass with four entries
        load4(16'd40, 16'd893, 16'd6023, 16'd9073);
        pulses = 0;
        go(4'd4, 24'd1000);
        full_seq();
        check("s1_pulses", pulses, 6);
        check("s1_idx", match_idx, 4);
        check("s1_pass", pass, 1);
        check("s1_code", fail_code, 0);
        do_clear();

        // Glitch on 893 shorter than STABLE, then stall into a timeout
        go(4'd4, 24'd1000);
        hold(ST, 5); hold(16'd40, 5); hold(16'd893, 1);
        chk_i = 16'h0000;
        wait_fail(1'b0, 1100, at, ok);
        check("s2_fail_seen", ok, 1);
        check("s2_code", fail_code, 1);
        check("s2_idx", match_idx, 1);
        check("s2_tmo_dist", 32'(at - last_pulse_cyc), 1000);
        do_clear();

        // Early END_TAG: strict instance fails, relaxed instance waits for timeout
        go(4'd4, 24'd1000);
        hold(ST, 5); hold(16'd40, 5); hold(EN, 3);
        check("s3_fail", fail, 1);
        check("s3_code", fail_code, 2);
        check("s3_idx", match_idx, 1);
        check("s3_ns_busy", busy_ns, 1);
        check("s3_ns_fail", fail_ns, 0);
        chk_i = 16'h0000;
        wait_fail(1'b1, 1100, at, ok);
        check("s3_ns_fail_seen", ok, 1);
        check("s3_ns_code", fail_code_ns, 1);
        check("s3_ns_tmo_dist", 32'(at - last_pulse_cyc), 1000);
        do_clear();

        // Empty table goes straight to END_TAG
        go(4'd0, 24'd1000);
        hold(ST, 5); hold(EN, 5);
        check("s4a_pass", pass, 1);
        check("s4a_idx", match_idx, 0);
        do_clear();

        // Two identical consecutive entries
        exp_we = 1'b1; exp_addr = 3'd0; exp_wdata = 16'd5; step();
        exp_addr = 3'd1; step();
        exp_we = 1'b0;
        pulses = 0;
        go(4'd2, 24'd1000);
        hold(ST, 5); hold(16'd5, 4); hold(EN, 5);
        check("s4b_pass", pass, 1);
        check("s4b_idx", match_idx, 2);
        check("s4b_pulses", pulses, 4);
        do_clear();

        // Clear together with start mid-run, then a write attempted while running
        load4(16'd40, 16'd893, 16'd6023, 16'd9073);
        go(4'd4, 24'd1000);
        hold(ST, 5); hold(16'd40, 5);
        check("s5_mid_idx", match_idx, 1);
        clear = 1'b1; start = 1'b1;
        step();
        clear = 1'b0; start = 1'b0;
        check("s5_clr_busy", busy, 0);
        check("s5_clr_idx", match_idx, 0);
        go(4'd4, 24'd1000);
        hold(ST, 5);
        exp_we = 1'b1; exp_addr = 3'd0; exp_wdata = 16'h1234;
        step();
        exp_we = 1'b0;
        do_clear();
        go(4'd4, 24'd1000);
        full_seq();
        check("s5_rerun_pass", pass, 1);
        check("s5_rerun_idx", match_idx, 4);
        do_clear();

        // Timeout disabled: long stall while armed
        go(4'd4, 24'd0);
        hold(16'h0000, 20000);
        check("s6_busy", busy, 1);
        check("s6_fail", fail, 0);
        do_clear();

        // Reset in the middle of a run
        go(4'd4, 24'd1000);
        hold(ST, 5); hold(16'd40, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("s6_rst_busy", busy, 0);
        check("s6_rst_pass", pass, 0);
        check("s6_rst_fail", fail, 0);
        check("s6_rst_code", fail_code, 0);
        check("s6_rst_pulse", match_pulse, 0);
        check("s6_rst_idx", match_idx, 0);
        check("s6_rst_ns_busy", busy_ns, 0);
        step();

        // Randomized sequences with random tables, lengths, limits and stray controls
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 8; i++) begin
                exp_we = 1'b1; exp_addr = 3'(i); exp_wdata = 16'($urandom_range(1, 6));
                step();
            end
            exp_we = 1'b0;
            go(4'($urandom_range(0, 10)), ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(15, 80)));
            for (int k = 0; k < 40; k++) begin
                r = int'($urandom_range(0, 7));
                if (r == 0) v = ST;
                else if (r == 1) v = EN;
                else if (r <= 4) v = m_tab[m_idx % 8];
                else if (r == 5) v = m_tab[$urandom_range(0, 7)];
                else v = 16'($urandom_range(0, 8));
                chk_i = v;
                if ($urandom_range(0, 39) == 0) clear = 1'b1;
                if ($urandom_range(0, 29) == 0) start = 1'b1;
                if ($urandom_range(0, 19) == 0) begin
                    exp_we = 1'b1; exp_addr = 3'($urandom_range(0, 7)); exp_wdata = 16'($urandom_range(1, 6));
                end
                n = int'($urandom_range(1, 4));
                step();
                clear = 1'b0; start = 1'b0; exp_we = 1'b0;
                repeat (n - 1) step();
            end
            do_clear();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
